rpatrol_rom_loader: RTL

RPATROL_ROM_LOADER -- requirements
Module: rpatrol_rom_loader

---
 rtl/rpatrol_rom_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rpatrol_rom_loader.sv
// ROM download front end for the River Patrol core.
// Splits the HPS byte stream into four ROM regions, validates the image and sequences the core reset.
module rpatrol_rom_loader #(
    parameter int HOLD_CYCLES  = 1024,
    parameter int EXPECT_BYTES = 37120
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ext_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [3:0]  rgn_sel,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [16:0] byte_count
);

    localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [16:0] EXPECT    = 17'(EXPECT_BYTES);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt;
    logic          hold_clr, hold_inc;
    logic          enter_load, to_run, accept;

    logic [15:0] addr_lo;
    logic        map_hit;
    logic [3:0]  map_rgn;
    logic [15:0] map_addr;

    assign addr_lo    = ioctl_addr[15:0];
    assign core_reset = (state_q != RUN);
    assign accept     = (state_q == LOAD) && ioctl_wr;
    assign enter_load = (state_d == LOAD) && (state_q != LOAD);
    assign to_run     = (state_q == HOLD) && (state_d == RUN);

    // Region decode; any nonzero upper address bit is out of range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        map_hit  = 1'b0;
        map_rgn  = 4'b0000;
        map_addr = 16'h0000;
        if (ioctl_addr[24:16] == 9'd0) begin
            if (addr_lo < 16'h6000) begin
                map_hit  = 1'b1;
                map_rgn  = 4'b0001;
                map_addr = addr_lo;
            end else if (addr_lo < 16'h8000) begin
                map_hit  = 1'b1;
                map_rgn  = 4'b0010;
                map_addr = addr_lo - 16'h6000;
            end else if (addr_lo < 16'h9000) begin
                map_hit  = 1'b1;
                map_rgn  = 4'b0100;
                map_addr = addr_lo - 16'h8000;
            end else if (addr_lo < 16'h9100) begin
                map_hit  = 1'b1;
                map_rgn  = 4'b1000;
                map_addr = addr_lo - 16'h9000;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_clr = 1'b0;
        hold_inc = 1'b0;
        case (state_q)
            WAIT: begin
                if (ioctl_download) state_d = LOAD;
            end
            LOAD: begin
                if (!ioctl_download) begin
                    state_d  = HOLD;
                    hold_clr = 1'b1;
                end
            end
            HOLD: begin
                // A new download wins over both the countdown and a user reset.
                if (ioctl_download) begin
                    state_d = LOAD;
                end else if (ext_reset) begin
                    hold_clr = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            RUN: begin
                if (ioctl_download) begin
                    state_d = LOAD;
                end else if (ext_reset) begin
                    state_d  = HOLD;
                    hold_clr = 1'b1;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_cnt   <= '0;
            dn_wr      <= 1'b0;
            dn_addr    <= 16'h0000;
            dn_data    <= 8'h00;
            rgn_sel    <= 4'b0000;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= 17'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            dn_wr <= 1'b0;

            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (enter_load) begin
                byte_count <= 17'd0;
                load_err   <= 1'b0;
                load_done  <= 1'b0;
            end else begin
                if (accept) begin
                    if (byte_count != 17'h1FFFF) byte_count <= byte_count + 17'd1;
                    if (!map_hit || (ioctl_addr != {8'd0, byte_count})) load_err <= 1'b1;
                    if (map_hit) begin
                        dn_wr   <= 1'b1;
                        dn_addr <= map_addr;
                        dn_data <= ioctl_dout;
                        rgn_sel <= map_rgn;
                    end
                end
                if ((state_q == LOAD) && !ioctl_download && (byte_count != EXPECT)) begin
                    load_err <= 1'b1;
                end
                if (to_run && !load_err) begin
                    load_done <= 1'b1;
                end
            end
        end
    end

endmodule
